// File: rtl/test_seq_pkg.sv
// ---------------------------------------------------------------------------
// test_seq_pkg
// Shared types for the FX3 test sequencer: the sequencer state encoding and
// the sticky error-cause codes reported on err_code.
// ---------------------------------------------------------------------------
package test_seq_pkg;

    // Sequencer states, fixed 3-bit encoding so the state is easy to read
    // back on a logic analyser.
    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        RST          = 3'd1,
        SETTLE       = 3'd2,
        RUN          = 3'd3,
        CHECK        = 3'd4,
        ATTEMPT_FAIL = 3'd5,
        DONE         = 3'd6,
        FAIL         = 3'd7
    } state_t;

    // Cause of the most recent failed attempt.
    typedef logic [2:0] err_code_t;

    localparam err_code_t ERR_NONE = 3'd0;
    localparam err_code_t ERR_CH   = 3'd1;
    localparam err_code_t ERR_WDOG = 3'd2;
    localparam err_code_t ERR_LINK = 3'd3;

endpackage

// File: rtl/test_sequencer_if.sv
// ---------------------------------------------------------------------------
// test_sequencer_if
// Bundles the link status, channel handshake and status outputs of the test
// sequencer.
//   master : the sequencer (drives hw_rst, ch_ena and status)
//   slave  : the environment (drives link status, rearm, channel done/err)
// Signals:
//   pll_lock, fx3_ready : link status, synchronous to clk
//   rearm               : single-cycle pulse to leave DONE/FAIL
//   ch_done, ch_err     : per-channel completion / error levels
//   hw_rst, ch_ena      : DUT reset and per-channel enables
//   busy, pass, fail    : coarse sequencer status
//   err_code, err_ch    : sticky error cause and failing channels
//   retry_cnt           : retries consumed in the current run
// ---------------------------------------------------------------------------
interface test_sequencer_if
    import test_seq_pkg::*;
#(
    parameter int N_CH = 2
) ();

    logic            pll_lock;
    logic            fx3_ready;
    logic            rearm;
    logic [N_CH-1:0] ch_done;
    logic [N_CH-1:0] ch_err;

    logic            hw_rst;
    logic [N_CH-1:0] ch_ena;
    logic            busy;
    logic            pass;
    logic            fail;
    err_code_t       err_code;
    logic [N_CH-1:0] err_ch;
    logic [2:0]      retry_cnt;

    modport master (
        input  pll_lock, fx3_ready, rearm, ch_done, ch_err,
        output hw_rst, ch_ena, busy, pass, fail, err_code, err_ch, retry_cnt
    );

    modport slave (
        output pll_lock, fx3_ready, rearm, ch_done, ch_err,
        input  hw_rst, ch_ena, busy, pass, fail, err_code, err_ch, retry_cnt
    );

endinterface

// File: rtl/test_sequencer_timer.sv
// ---------------------------------------------------------------------------
// seq_timer
// Phase timer shared by the reset, settle and watchdog phases.
// Ports:
//   clk, arst : clock and asynchronous active-low reset
//   clr       : clear the count to zero (takes priority over en)
//   en        : advance the count by one
//   limit     : phase length in cycles
//   hit       : high while count == limit-1 (last cycle of the phase)
// The count saturates at all-ones instead of wrapping.
// ---------------------------------------------------------------------------
module seq_timer #(
    parameter int TMR_W = 16
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             clr,
    input  logic             en,
    input  logic [TMR_W-1:0] limit,
    output logic             hit
);

    localparam logic [TMR_W-1:0] TMR_ONE = TMR_W'(1);
    localparam logic [TMR_W-1:0] TMR_MAX = '1;

    logic [TMR_W-1:0] count_q;
    logic [TMR_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q != TMR_MAX)) begin
            count_d = count_q + TMR_ONE;
        end
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign hit = (count_q == (limit - TMR_ONE));

endmodule

// File: rtl/test_sequencer.sv
// ---------------------------------------------------------------------------
// test_sequencer
// Top-level FX3 test sequencer. Waits for link (PLL lock and FX3 ready),
// pulses hw_rst for RST_CYCLES, waits SETTLE_CYCLES, then runs N_CH test
// channels in parallel under a watchdog. Failed attempts (channel error,
// watchdog, link loss) are retried up to MAX_RETRY times; the final result
// is held in DONE/FAIL until a rearm pulse.
// Ports:
//   clk  : system clock (40 MHz)
//   arst : asynchronous active-low reset
//   bus  : test_sequencer_if master modport (link, channels, status)
// All status outputs are registered from the current state, so they follow
// a state change by one cycle.
// ---------------------------------------------------------------------------
module test_sequencer
    import test_seq_pkg::*;
#(
    parameter int RST_CYCLES    = 8000,
    parameter int SETTLE_CYCLES = 16,
    parameter int WDOG_CYCLES   = 65535,
    parameter int TMR_W         = 16,
    parameter int N_CH          = 2,
    parameter int MAX_RETRY     = 2
) (
    input  logic             clk,
    input  logic             arst,
    test_sequencer_if.master bus
);

    localparam logic [TMR_W-1:0] RST_LIM    = TMR_W'(RST_CYCLES);
    localparam logic [TMR_W-1:0] SETTLE_LIM = TMR_W'(SETTLE_CYCLES);
    localparam logic [TMR_W-1:0] WDOG_LIM   = TMR_W'(WDOG_CYCLES);
    localparam logic [2:0]       RETRY_MAX  = 3'(MAX_RETRY);

    state_t          state_q, state_d;
    logic [N_CH-1:0] doneSeen_q, doneSeen_d;
    logic [N_CH-1:0] errCh_q, errCh_d;
    err_code_t       errCode_q, errCode_d;
    logic [2:0]      retryCnt_q, retryCnt_d;
    logic            rstArmed_q, rstArmed_d;
    logic            hwRst_q, hwRst_d;
    logic [N_CH-1:0] chEna_q, chEna_d;
    logic            busy_q, busy_d;
    logic            pass_q, pass_d;
    logic            fail_q, fail_d;

    logic             link;
    logic             allDone;
    logic             tmrClr;
    logic             tmrEn;
    logic [TMR_W-1:0] tmrLimit;
    logic             tmrHit;

    assign link    = bus.pll_lock & bus.fx3_ready;
    assign allDone = &(doneSeen_q | bus.ch_done);

    seq_timer #(
        .TMR_W (TMR_W)
    ) uTimer (
        .clk   (clk),
        .arst  (arst),
        .clr   (tmrClr),
        .en    (tmrEn),
        .limit (tmrLimit),
        .hit   (tmrHit)
    );

    // Next-state and status logic. rstArmed remembers that link has been
    // seen during the current RST visit: a retry entered while the link is
    // still down must wait for relock, not count as another link loss.
    // The timer is cleared on every state change.
    always_comb begin
        state_d    = state_q;
        doneSeen_d = doneSeen_q;
        errCh_d    = errCh_q;
        errCode_d  = errCode_q;
        retryCnt_d = retryCnt_q;
        rstArmed_d = 1'b0;
        tmrEn      = 1'b0;
        tmrLimit   = RST_LIM;

        case (state_q)
            IDLE: begin
                if (link) begin
                    state_d = RST;
                end
            end

            RST: begin
                tmrLimit   = RST_LIM;
                tmrEn      = link;
                rstArmed_d = rstArmed_q | link;
                if (!link && rstArmed_q) begin
                    errCode_d = ERR_LINK;
                    state_d   = ATTEMPT_FAIL;
                end else if (link && tmrHit) begin
                    state_d = (SETTLE_CYCLES == 0) ? RUN : SETTLE;
                end
            end

            SETTLE: begin
                tmrLimit = SETTLE_LIM;
                tmrEn    = 1'b1;
                if (!link) begin
                    errCode_d = ERR_LINK;
                    state_d   = ATTEMPT_FAIL;
                end else if (tmrHit) begin
                    state_d = RUN;
                end
            end

            RUN: begin
                tmrLimit   = WDOG_LIM;
                tmrEn      = 1'b1;
                doneSeen_d = doneSeen_q | bus.ch_done;
                errCh_d    = errCh_q | (bus.ch_done & bus.ch_err);
                // Link loss beats completion, completion beats the watchdog.
                if (!link) begin
                    errCode_d = ERR_LINK;
                    state_d   = ATTEMPT_FAIL;
                end else if (allDone) begin
                    state_d = CHECK;
                end else if (tmrHit) begin
                    errCode_d = ERR_WDOG;
                    state_d   = ATTEMPT_FAIL;
                end
            end

            CHECK: begin
                if (errCh_q == '0) begin
                    state_d = DONE;
                end else begin
                    errCode_d = ERR_CH;
                    state_d   = ATTEMPT_FAIL;
                end
            end

            ATTEMPT_FAIL: begin
                if (retryCnt_q < RETRY_MAX) begin
                    retryCnt_d = retryCnt_q + 3'd1;
                    doneSeen_d = '0;
                    errCh_d    = '0;
                    state_d    = RST;
                end else begin
                    state_d = FAIL;
                end
            end

            DONE, FAIL: begin
                if (bus.rearm) begin
                    errCode_d  = ERR_NONE;
                    errCh_d    = '0;
                    retryCnt_d = '0;
                    doneSeen_d = '0;
                    state_d    = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        tmrClr = (state_d != state_q);
    end

    // Registered outputs derived from the current state. hw_rst is held
    // through ATTEMPT_FAIL when it was already high, so a link loss in RST
    // keeps the DUT in reset continuously across the retry.
    always_comb begin
        hwRst_d = (state_q == RST) || ((state_q == ATTEMPT_FAIL) && hwRst_q);
        chEna_d = (state_q == RUN) ? ~(doneSeen_q | bus.ch_done) : '0;
        busy_d  = (state_q == RST) || (state_q == SETTLE) || (state_q == RUN);
        pass_d  = (state_q == DONE);
        fail_d  = (state_q == FAIL);
    end

    // State and status registers.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state_q    <= IDLE;
            doneSeen_q <= '0;
            errCh_q    <= '0;
            errCode_q  <= ERR_NONE;
            retryCnt_q <= '0;
            rstArmed_q <= 1'b0;
            hwRst_q    <= 1'b0;
            chEna_q    <= '0;
            busy_q     <= 1'b0;
            pass_q     <= 1'b0;
            fail_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            doneSeen_q <= doneSeen_d;
            errCh_q    <= errCh_d;
            errCode_q  <= errCode_d;
            retryCnt_q <= retryCnt_d;
            rstArmed_q <= rstArmed_d;
            hwRst_q    <= hwRst_d;
            chEna_q    <= chEna_d;
            busy_q     <= busy_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
        end
    end

    assign bus.hw_rst    = hwRst_q;
    assign bus.ch_ena    = chEna_q;
    assign bus.busy      = busy_q;
    assign bus.pass      = pass_q;
    assign bus.fail      = fail_q;
    assign bus.err_code  = errCode_q;
    assign bus.err_ch    = errCh_q;
    assign bus.retry_cnt = retryCnt_q;

endmodule

// File: tb/tb_test_sequencer.sv
// ---------------------------------------------------------------------------
// tb_test_sequencer
// Directed bench for test_sequencer with N_CH=2, RST_CYCLES=8,
// SETTLE_CYCLES=4, WDOG_CYCLES=20, MAX_RETRY=2. Each run's expected final
// status is queued when its stimulus starts and compared once the DUT
// reaches pass or fail.
// ---------------------------------------------------------------------------
module tb_test_sequencer;

    localparam int RST_CYC    = 8;
    localparam int SETTLE_CYC = 4;
    localparam int WDOG_CYC   = 20;
    localparam int BUDGET     = 300;

    typedef struct packed {
        logic       pass;
        logic       fail;
        logic [2:0] code;
        logic [1:0] errCh;
        logic [2:0] retry;
        logic [7:0] pulses;
    } exp_t;

    typedef enum int {W_HWRST_HI, W_HWRST_LO, W_ENA_HI, W_ENA_LO, W_TERM} waitSel_t;

    logic clk;
    logic arst;
    int   checks    = 0;
    int   failures  = 0;
    int   pulses    = 0;
    int   n         = 0;
    logic prevHwRst = 1'b0;
    exp_t sbQ[$];

    test_sequencer_if #(.N_CH(2)) bus ();

    test_sequencer #(
        .RST_CYCLES    (RST_CYC),
        .SETTLE_CYCLES (SETTLE_CYC),
        .WDOG_CYCLES   (WDOG_CYC),
        .TMR_W         (16),
        .N_CH          (2),
        .MAX_RETRY     (2)
    ) dut (
        .clk  (clk),
        .arst (arst),
        .bus  (bus)
    );

    // 10 ns clock; the DUT acts on the rising edge, the bench on the falling.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the directed sequence ever stalls.
    initial begin
        #500000;
        $display("[TB] FAIL global_timeout observed=stalled expected=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] done, input logic [1:0] err);
        bus.ch_done = done;
        bus.ch_err  = err;
    endtask

    // One falling edge; counts rising edges of hw_rst as reset pulses.
    task automatic tick();
        @(negedge clk);
        if (bus.hw_rst && !prevHwRst) begin
            pulses++;
        end
        prevHwRst = bus.hw_rst;
    endtask

    task automatic tickN(input int k);
        for (int i = 0; i < k; i++) begin
            tick();
        end
    endtask

    function automatic logic [31:0] outVec();
        return 32'({bus.hw_rst, bus.ch_ena, bus.busy, bus.pass, bus.fail,
                    bus.err_code, bus.err_ch, bus.retry_cnt});
    endfunction

    // Ticks until the selected condition holds; cnt is the number of ticks.
    task automatic tickUntil(input waitSel_t sel, input string tag, output int cnt);
        logic hit;
        hit = 1'b0;
        cnt = 0;
        while (!hit && cnt < BUDGET) begin
            tick();
            cnt++;
            case (sel)
                W_HWRST_HI: hit = bus.hw_rst;
                W_HWRST_LO: hit = !bus.hw_rst;
                W_ENA_HI:   hit = (bus.ch_ena != 2'b00);
                W_ENA_LO:   hit = (bus.ch_ena == 2'b00);
                default:    hit = bus.pass | bus.fail;
            endcase
        end
        checkOutput({tag, "_reached"}, 32'(hit), 32'd1);
    endtask

    function automatic exp_t mkExp(input logic p, input logic f, input logic [2:0] code,
                                   input logic [1:0] ec, input logic [2:0] r, input int pl);
        exp_t e;
        e.pass   = p;
        e.fail   = f;
        e.code   = code;
        e.errCh  = ec;
        e.retry  = r;
        e.pulses = 8'(pl);
        return e;
    endfunction

    // Waits for DONE/FAIL and compares the final status with the oldest
    // queued expectation.
    task automatic waitTerminal(input string tag);
        exp_t e;
        tickUntil(W_TERM, tag, n);
        checkOutput({tag, "_sb_nonempty"}, 32'(sbQ.size() != 0), 32'd1);
        if (sbQ.size() != 0) begin
            e = sbQ.pop_front();
            checkOutput({tag, "_pass"},      32'(bus.pass),      32'(e.pass));
            checkOutput({tag, "_fail"},      32'(bus.fail),      32'(e.fail));
            checkOutput({tag, "_err_code"},  32'(bus.err_code),  32'(e.code));
            checkOutput({tag, "_err_ch"},    32'(bus.err_ch),    32'(e.errCh));
            checkOutput({tag, "_retry_cnt"}, 32'(bus.retry_cnt), 32'(e.retry));
            checkOutput({tag, "_hw_rst_pulses"}, 32'(pulses),    32'(e.pulses));
        end
    endtask

    // Drives done/err for one cycle, checks ch_ena drops, then releases.
    task automatic finishAttempt(input string tag, input logic [1:0] done, input logic [1:0] err);
        applyStimulus(done, err);
        tick();
        checkOutput({tag, "_ena_drop"}, 32'(bus.ch_ena), 32'd0);
        applyStimulus(2'b00, 2'b00);
    endtask

    // Rearm pulse from DONE/FAIL: status clears, and with link up a new
    // hw_rst pulse starts right away.
    task automatic rearmRun(input string tag);
        pulses = 0;
        bus.rearm = 1'b1;
        tick();
        bus.rearm = 1'b0;
        tick();
        checkOutput({tag, "_cleared"}, outVec(), 32'd0);
        tick();
        checkOutput({tag, "_restart"}, 32'({bus.busy, bus.hw_rst}), 32'b11);
    endtask

    initial begin
        arst = 1'b0;
        bus.pll_lock  = 1'b1;
        bus.fx3_ready = 1'b1;
        bus.rearm     = 1'b0;
        applyStimulus(2'b00, 2'b00);

        // Reset state: all outputs low even though link is up.
        tickN(3);
        checkOutput("reset_outputs", outVec(), 32'd0);

        // Run 1: clean pass, timing of hw_rst and channel enable.
        sbQ.push_back(mkExp(1'b1, 1'b0, 3'd0, 2'b00, 3'd0, 1));
        arst = 1'b1;
        pulses = 0;
        tickUntil(W_HWRST_HI, "r1_hwrst_rise", n);
        tickUntil(W_HWRST_LO, "r1_hwrst_fall", n);
        checkOutput("r1_hwrst_len", 32'(n), 32'(RST_CYC));
        tickUntil(W_ENA_HI, "r1_ena_rise", n);
        checkOutput("r1_settle_gap", 32'(n), 32'(SETTLE_CYC));
        checkOutput("r1_ena_value", 32'(bus.ch_ena), 32'b11);
        tickN(9);
        finishAttempt("r1", 2'b11, 2'b00);
        waitTerminal("r1");

        // Run 2: channel 1 errors on every attempt -> FAIL after 2 retries.
        rearmRun("r2_rearm");
        sbQ.push_back(mkExp(1'b0, 1'b1, 3'd1, 2'b10, 3'd2, 3));
        for (int a = 0; a < 3; a++) begin
            tickUntil(W_ENA_HI, "r2_ena_rise", n);
            tickN(2);
            finishAttempt("r2", 2'b11, 2'b10);
        end
        waitTerminal("r2");

        // Run 3: watchdog on first attempt, pass on the retry.
        rearmRun("r3_rearm");
        sbQ.push_back(mkExp(1'b1, 1'b0, 3'd2, 2'b00, 3'd1, 2));
        tickUntil(W_ENA_HI, "r3_ena_rise", n);
        tickUntil(W_ENA_LO, "r3_wdog", n);
        checkOutput("r3_wdog_len", 32'(n), 32'(WDOG_CYC));
        checkOutput("r3_wdog_code", 32'(bus.err_code), 32'd2);
        checkOutput("r3_wdog_retry", 32'(bus.retry_cnt), 32'd1);
        tickUntil(W_ENA_HI, "r3_retry_ena", n);
        tickN(3);
        finishAttempt("r3", 2'b11, 2'b00);
        waitTerminal("r3");

        // Run 4: pll_lock drops for 5 cycles mid-RST; hw_rst stays high and
        // the full reset count restarts after relock.
        rearmRun("r4_rearm");
        sbQ.push_back(mkExp(1'b1, 1'b0, 3'd3, 2'b00, 3'd1, 1));
        tickN(3);
        bus.pll_lock = 1'b0;
        tick();
        checkOutput("r4_link_code", 32'(bus.err_code), 32'd3);
        checkOutput("r4_hwrst_hold", 32'(bus.hw_rst), 32'd1);
        tickN(4);
        checkOutput("r4_hold_state", 32'({bus.hw_rst, bus.busy, bus.retry_cnt}), 32'b11_001);
        bus.pll_lock = 1'b1;
        tickUntil(W_HWRST_LO, "r4_relock", n);
        checkOutput("r4_relock_len", 32'(n), 32'(RST_CYC + 1));
        tickUntil(W_ENA_HI, "r4_ena_rise", n);
        tickN(3);
        finishAttempt("r4", 2'b11, 2'b00);
        waitTerminal("r4");

        // Run 5: both channels done in the watchdog expiry cycle -> DONE.
        rearmRun("r5_rearm");
        sbQ.push_back(mkExp(1'b1, 1'b0, 3'd0, 2'b00, 3'd0, 1));
        tickUntil(W_ENA_HI, "r5_ena_rise", n);
        tickN(WDOG_CYC - 2);
        finishAttempt("r5", 2'b11, 2'b00);
        waitTerminal("r5");

        // Run 6: asynchronous reset in the RUN phase of a retry.
        rearmRun("r6_rearm");
        tickUntil(W_ENA_HI, "r6_ena_rise", n);
        tickUntil(W_ENA_LO, "r6_wdog", n);
        tickUntil(W_ENA_HI, "r6_retry_ena", n);
        tickN(3);
        checkOutput("r6_pre_reset", 32'({bus.err_code, bus.retry_cnt, bus.ch_ena}), 32'b010_001_11);
        arst = 1'b0;
        #1;
        checkOutput("r6_async_reset", outVec(), 32'd0);
        tickN(2);
        arst = 1'b1;
        pulses = 0;
        sbQ.push_back(mkExp(1'b1, 1'b0, 3'd0, 2'b00, 3'd0, 1));
        tickUntil(W_ENA_HI, "r6_ena_after_reset", n);
        tickN(3);
        finishAttempt("r6", 2'b11, 2'b00);
        waitTerminal("r6");

        checkOutput("sb_drained", 32'(sbQ.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
